traffic_light_ctrl: RTL

Parametrised two-road intersection controller. Road A is the main road and road B the side road. Replaces a fixed chain of per-cycle states with a single tick-driven phase timer. Adds min/max green, all-red clearance, a latched pedestrian walk phase and a flashing-yellow fault mode. Sits between the sensor/tick-prescaler logic and the lamp drivers.

---
 rtl/tl_pkg.sv | 52 +++++
 rtl/tl_phase_timer.sv | 33 +++
 rtl/traffic_light_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/tl_pkg.sv
// Shared types and constants for the two-road traffic light controller:
// state encoding, per-state lamp vectors and default timing values.
package tl_pkg;

  // Phase encoding exposed on the phase output.
  typedef enum logic [2:0] {
    A_GREEN  = 3'd0,
    A_YELLOW = 3'd1,
    ALLRED_1 = 3'd2,
    B_GREEN  = 3'd3,
    B_YELLOW = 3'd4,
    ALLRED_2 = 3'd5,
    PED_WALK = 3'd6,
    FLASH    = 3'd7
  } tl_state_e;

  // Lamp vector bit order: {ga, ya, ra, gb, yb, rb, walk}.
  typedef logic [6:0] lamp_t;

  localparam lamp_t LAMP_A_GREEN  = 7'b100_0010;
  localparam lamp_t LAMP_A_YELLOW = 7'b010_0010;
  localparam lamp_t LAMP_ALLRED   = 7'b001_0010;
  localparam lamp_t LAMP_B_GREEN  = 7'b001_1000;
  localparam lamp_t LAMP_B_YELLOW = 7'b001_0100;
  localparam lamp_t LAMP_PED_WALK = 7'b001_0011;
  localparam lamp_t LAMP_DARK     = 7'b000_0000;

  // Default timing, all in tick units.
  localparam int DEF_CNT_W     = 8;
  localparam int DEF_MIN_GREEN = 6;
  localparam int DEF_MAX_GREEN = 20;
  localparam int DEF_YELLOW_T  = 2;
  localparam int DEF_ALLRED_T  = 1;
  localparam int DEF_WALK_T    = 4;

  // Lamp pattern shown while in a given state; FLASH blinks both yellows.
  function automatic lamp_t lamp_of(input tl_state_e st, input logic blink);
    lamp_t v;
    case (st)
      A_GREEN:            v = LAMP_A_GREEN;
      A_YELLOW:           v = LAMP_A_YELLOW;
      ALLRED_1, ALLRED_2: v = LAMP_ALLRED;
      B_GREEN:            v = LAMP_B_GREEN;
      B_YELLOW:           v = LAMP_B_YELLOW;
      PED_WALK:           v = LAMP_PED_WALK;
      FLASH:              v = {1'b0, blink, 1'b0, 1'b0, blink, 1'b0, 1'b0};
      default:            v = LAMP_DARK;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// Saturating tick counter for the current phase. Cleared synchronously on a
// phase change; done flags the last tick of a phase of length dur.
module tl_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             tick,
  input  logic [CNT_W-1:0] dur,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // cnt holds the number of ticks already served in this phase.
  assign done = (cnt == (dur - CNT_W'(1)));

  // Count ticks, hold at all-ones, restart at every phase change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt <= {CNT_W{1'b0}};
    end else if (tick && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-road intersection controller: main road A, side road B, min/max green,
// all-red clearance, latched pedestrian walk phase and flashing-yellow mode.
module traffic_light_ctrl
  import tl_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int MIN_GREEN = DEF_MIN_GREEN,
  parameter int MAX_GREEN = DEF_MAX_GREEN,
  parameter int YELLOW_T  = DEF_YELLOW_T,
  parameter int ALLRED_T  = DEF_ALLRED_T,
  parameter int WALK_T    = DEF_WALK_T
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       sa,
  input  logic       sb,
  input  logic       ped_req,
  input  logic       flash_en,
  output logic       ga,
  output logic       ya,
  output logic       ra,
  output logic       gb,
  output logic       yb,
  output logic       rb,
  output logic       walk,
  output logic [2:0] phase
);

  if (MIN_GREEN < 1 || MAX_GREEN < MIN_GREEN || MAX_GREEN >= (2 ** CNT_W)) begin : g_bad_green
    $fatal(1, "traffic_light_ctrl: green limits out of range");
  end
  if (YELLOW_T < 1 || ALLRED_T < 1 || WALK_T < 1) begin : g_bad_dur
    $fatal(1, "traffic_light_ctrl: phase durations must be >= 1");
  end
  if (YELLOW_T >= (2 ** CNT_W) || ALLRED_T >= (2 ** CNT_W) || WALK_T >= (2 ** CNT_W)) begin : g_bad_width
    $fatal(1, "traffic_light_ctrl: phase duration does not fit the timer");
  end

  localparam logic [CNT_W-1:0] MIN_M1 = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_M1 = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_D  = CNT_W'(YELLOW_T);
  localparam logic [CNT_W-1:0] ARED_D = CNT_W'(ALLRED_T);
  localparam logic [CNT_W-1:0] WALK_D = CNT_W'(WALK_T);

  tl_state_e        state_r;
  tl_state_e        base_nxt_s;
  tl_state_e        state_nxt_s;
  logic             ped_pending_r;
  logic             ped_nxt_s;
  logic             blink_r;
  logic             blink_nxt_s;
  lamp_t            lamp_r;
  logic [CNT_W-1:0] cnt_s;
  logic [CNT_W-1:0] dur_s;
  logic             done_s;
  logic             clr_s;
  logic             min_ok_s;
  logic             max_ok_s;

  assign min_ok_s    = (cnt_s >= MIN_M1);
  assign max_ok_s    = (cnt_s >= MAX_M1);
  // Fault/night mode overrides everything and is not tick-gated.
  assign state_nxt_s = flash_en ? FLASH : base_nxt_s;
  assign clr_s       = (state_nxt_s != state_r);

  tl_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_s),
    .tick  (tick),
    .dur   (dur_s),
    .cnt   (cnt_s),
    .done  (done_s)
  );

  // Normal phase sequencing and the duration of the current fixed phase.
  always_comb begin
    base_nxt_s = state_r;
    dur_s      = YEL_D;
    case (state_r)
      A_GREEN: begin
        if (tick && min_ok_s && (sb || ped_pending_r) && (!sa || max_ok_s)) base_nxt_s = A_YELLOW;
        else base_nxt_s = A_GREEN;
      end
      A_YELLOW: begin
        dur_s = YEL_D;
        if (tick && done_s) base_nxt_s = ALLRED_1;
        else base_nxt_s = A_YELLOW;
      end
      ALLRED_1: begin
        dur_s = ARED_D;
        if (tick && done_s) base_nxt_s = B_GREEN;
        else base_nxt_s = ALLRED_1;
      end
      B_GREEN: begin
        if (tick && ((min_ok_s && (!sb || sa || ped_pending_r)) || max_ok_s)) base_nxt_s = B_YELLOW;
        else base_nxt_s = B_GREEN;
      end
      B_YELLOW: begin
        dur_s = YEL_D;
        if (tick && done_s) base_nxt_s = ALLRED_2;
        else base_nxt_s = B_YELLOW;
      end
      ALLRED_2: begin
        dur_s = ARED_D;
        if (tick && done_s) base_nxt_s = ped_pending_r ? PED_WALK : A_GREEN;
        else base_nxt_s = ALLRED_2;
      end
      PED_WALK: begin
        dur_s = WALK_D;
        if (tick && done_s) base_nxt_s = A_GREEN;
        else base_nxt_s = PED_WALK;
      end
      // Only taken when flash_en has dropped: clear the junction first.
      FLASH:   base_nxt_s = ALLRED_2;
      default: base_nxt_s = A_GREEN;
    endcase
  end

  // Pedestrian latch and flash blink phase for the next cycle.
  always_comb begin
    if ((state_nxt_s == PED_WALK) && (state_r != PED_WALK)) ped_nxt_s = 1'b0;
    else if (ped_req && (state_r != PED_WALK)) ped_nxt_s = 1'b1;
    else ped_nxt_s = ped_pending_r;

    if ((state_nxt_s != FLASH) || (state_r != FLASH)) blink_nxt_s = 1'b0;
    else if (tick) blink_nxt_s = !blink_r;
    else blink_nxt_s = blink_r;
  end

  // State, pedestrian latch, blink and lamp registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= A_GREEN;
      ped_pending_r <= 1'b0;
      blink_r       <= 1'b0;
      lamp_r        <= LAMP_A_GREEN;
    end else begin
      state_r       <= state_nxt_s;
      ped_pending_r <= ped_nxt_s;
      blink_r       <= blink_nxt_s;
      lamp_r        <= lamp_of(state_nxt_s, blink_nxt_s);
    end
  end

  assign {ga, ya, ra, gb, yb, rb, walk} = lamp_r;
  assign phase = state_r;

endmodule
